// File: rtl/uvmt_dadder_bcd_chkr.sv
// Reference checker for the decimal adder/subtracter: predicts each BCD result, queues it in
// order, and scores DUT output beats for mismatch, overflow, underflow and timeout errors.
module uvmt_dadder_bcd_chkr #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned MAX_LATENCY = 16,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0,
  localparam int unsigned W  = 4 * NUM_DIGITS,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             out_valid,
  input  logic [W-1:0]     out_result,
  input  logic             out_cb,
  output logic             mismatch,
  output logic             err_sticky,
  output logic             fail,
  output logic [LW-1:0]    level,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned AW = $clog2(MAX_LATENCY + 1);
  localparam int unsigned EW = W + 1;

  typedef enum logic [0:0] {StRun, StFail} state_e;

  state_e           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [AW-1:0]    age_q, age_d;
  logic             mismatch_q, mismatch_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic [W-1:0]  exp_res;
  logic          exp_cb;
  logic          in_legal;
  logic [3:0]    da, db;
  logic [4:0]    dsum;
  logic          cy;

  logic          run, empty, full;
  logic [EW-1:0] head;
  logic          do_pop, underflow, timeout, cmp_bad, cmp_ok;
  logic          push_req, illegal, do_push, overflow, err_evt, remove;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Digit-serial ripple; subtraction borrows 10 per digit, giving the ten's complement result.
  always_comb begin
    exp_res  = '0;
    in_legal = 1'b1;
    cy       = 1'b0;
    da       = '0;
    db       = '0;
    dsum     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      da = in_a[4*i +: 4];
      db = in_b[4*i +: 4];
      if ((da > 4'd9) || (db > 4'd9)) in_legal = 1'b0;
      if (!in_op) begin
        dsum = {1'b0, da} + {1'b0, db} + {4'b0, cy};
        cy   = (dsum > 5'd9);
        if (cy) dsum = dsum - 5'd10;
      end else begin
        dsum = {1'b0, da} - {1'b0, db} - {4'b0, cy};
        cy   = dsum[4];
        if (cy) dsum = dsum + 5'd10;
      end
      exp_res[4*i +: 4] = dsum[3:0];
    end
    exp_cb = cy;
  end

  assign run       = (state_q == StRun);
  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign head      = mem_q[rd_ptr_q];
  assign do_pop    = run & out_valid & ~empty;
  assign underflow = run & out_valid & empty;
  // A pop in the same cycle as expiry wins; the head is compared rather than discarded.
  assign timeout   = run & ~out_valid & ~empty & (age_q == AW'(MAX_LATENCY));
  assign cmp_bad   = do_pop & (head != {out_result, out_cb});
  assign cmp_ok    = do_pop & ~cmp_bad;
  assign remove    = do_pop | timeout;
  assign push_req  = run & in_valid & in_legal;
  assign illegal   = run & in_valid & ~in_legal;
  assign do_push   = push_req & (~full | remove);
  assign overflow  = push_req & ~do_push;
  assign err_evt   = cmp_bad | overflow | underflow | timeout;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q + PW'(do_push);
    rd_ptr_d      = rd_ptr_q + PW'(remove);
    level_d       = level_q;
    age_d         = age_q;
    mismatch_d    = cmp_bad;
    err_sticky_d  = err_sticky_q | err_evt;
    match_cnt_d   = sat_inc(match_cnt_q, cmp_ok);
    err_cnt_d     = sat_inc(err_cnt_q, err_evt);
    illegal_cnt_d = sat_inc(illegal_cnt_q, illegal);

    unique case ({do_push, remove})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (run) begin
      if (remove || empty) age_d = '0;
      else                 age_d = age_q + AW'(1);
      if (err_evt && STOP_ON_ERR) state_d = StFail;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      age_q         <= '0;
      mismatch_q    <= 1'b0;
      err_sticky_q  <= 1'b0;
      match_cnt_q   <= '0;
      err_cnt_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      age_q         <= age_d;
      mismatch_q    <= mismatch_d;
      err_sticky_q  <= err_sticky_d;
      match_cnt_q   <= match_cnt_d;
      err_cnt_q     <= err_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= {exp_res, exp_cb};
  end

  assign mismatch    = mismatch_q;
  assign err_sticky  = err_sticky_q;
  assign fail        = (state_q == StFail);
  assign level       = level_q;
  assign match_cnt   = match_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule
